// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc encoding constants: opcodes, modifiers,
// field positions, the NOP word and the loader FSM state type.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [1:0] MOD_DEF = 2'b00;
    localparam logic [1:0] MOD_U   = 2'b01;
    localparam logic [1:0] MOD_H   = 2'b10;

    localparam int OPC_LSB = 27;
    localparam int I_BIT   = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 18;
    localparam int RS2_LSB = 14;
    localparam int MOD_LSB = 16;

    localparam logic [31:0] NOP_WORD = 32'h6800_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-level instruction handshake between a program source
// (master) and the encoder (slave).
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic        in_i;
    logic [1:0]  in_mod;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_opcode, in_i, in_mod,
        output in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_i, in_mod,
        input  in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous DEPTH x W word buffer; head reads as zero
// when empty so the memory data bus idles at 0.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_do_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + (PW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_cnt <= r_cnt - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// SimpleRisc instruction encoder and sequential program loader.
// Define IMM_RANGE_CHECK_EN to flag out-of-range immediates as errors.
module instr_encoder #(
    parameter int AW         = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    instr_encoder_if.slave in_if,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   instr_count,
    output logic          err,
    output logic [7:0]    err_count
);

    import simplerisc_pkg::*;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [7:0]    r_err_cnt;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_cnt;

    logic [4:0]    w_op;
    logic          w_is_alu;
    logic          w_is_ldst;
    logic          w_is_br;
    logic          w_is_bare;
    logic [31:0]   w_word;
    logic          w_illegal;
    logic          w_range_err;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [31:0]   w_head;
    logic          w_unused;

    assign w_op      = in_if.in_opcode;
    assign w_is_alu  = (w_op <= OP_ASR) && (w_op != OP_NOP);
    assign w_is_ldst = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_is_br   = (w_op >= OP_BEQ) && (w_op <= OP_CALL);
    assign w_is_bare = (w_op == OP_NOP) || (w_op == OP_RET);
    assign w_unused  = ^in_if.in_imm[31:27];

    always_comb begin
        w_word    = '0;
        w_illegal = 1'b0;
        w_word[OPC_LSB +: 5] = w_op;
        unique case (1'b1)
            w_is_alu: begin
                w_word[I_BIT] = in_if.in_i;
                if (w_op != OP_CMP) begin
                    w_word[RD_LSB +: 4] = in_if.in_rd;
                end
                if (w_op != OP_NOT && w_op != OP_MOV) begin
                    w_word[RS1_LSB +: 4] = in_if.in_rs1;
                end
                if (in_if.in_i) begin
                    w_word[MOD_LSB +: 2] = in_if.in_mod;
                    w_word[15:0] = in_if.in_imm[15:0];
                end else begin
                    w_word[RS2_LSB +: 4] = in_if.in_rs2;
                end
            end
            w_is_ldst: begin
                w_word[I_BIT] = 1'b1;
                w_word[RD_LSB +: 4] = in_if.in_rd;
                w_word[RS1_LSB +: 4] = in_if.in_rs1;
                w_word[MOD_LSB +: 2] = in_if.in_mod;
                w_word[15:0] = in_if.in_imm[15:0];
            end
            w_is_br: begin
                w_word[26:0] = in_if.in_imm[26:0];
            end
            w_is_bare: begin
                w_word[OPC_LSB +: 5] = w_op;
            end
            default: begin
                w_word    = NOP_WORD;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must survive truncation to the field it lands in.
    always_comb begin
        w_range_err = 1'b0;
        if ((w_is_alu && in_if.in_i) || w_is_ldst) begin
            case (in_if.in_mod)
                MOD_DEF: w_range_err =
                    !((&in_if.in_imm[31:15]) || !(|in_if.in_imm[31:15]));
                MOD_U:   w_range_err = |in_if.in_imm[31:16];
                MOD_H:   w_range_err = |in_if.in_imm[15:0];
                default: w_range_err = 1'b0;
            endcase
        end else if (w_is_br) begin
            w_range_err =
                !((&in_if.in_imm[31:26]) || !(|in_if.in_imm[31:26]));
        end
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_in_ready     = (r_state == S_LOAD) && !w_full;
    assign in_if.in_ready = w_in_ready;
    assign w_push         = w_in_ready && in_if.in_valid;
    assign w_pop          = !w_empty && mem_ready;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_push && in_if.in_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_addr    <= base_addr;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_addr <= r_addr + AW'(1);
                r_cnt  <= r_cnt + (AW+1)'(1);
            end
            if (w_push && (w_illegal || w_range_err)) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign mem_we      = !w_empty;
    assign mem_wdata   = w_head;
    assign mem_addr    = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign instr_count = r_cnt;
    assign err         = r_err;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encode table, back-pressure, address wrap
// and mid-load reset, with a write scoreboard on the memory port.
module tb_instr_encoder;

    localparam int AW = 10;
    localparam int FD = 4;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic        i;
        logic [1:0]  md;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_ready = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   instr_count;
    logic          err;
    logic [7:0]    err_count;

    int            total = 0;
    int            bad = 0;
    int            acc = 0;
    logic [AW-1:0] exp_addr = '0;
    wr_t           sb[$];
    wr_t           e;
    vec_t          vt[14];

    instr_encoder_if ifc ();

    instr_encoder #(
        .AW         (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .in_if       (ifc),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Memory-side monitor: every accepted write pops the scoreboard.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got=%0h@%0h want=none",
                         mem_wdata, mem_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    function automatic logic [31:0] add_word(input int k);
        logic [3:0] a = 4'(k);
        logic [3:0] b = 4'(k + 1);
        logic [3:0] c = 4'(k + 2);
        return {5'd0, 1'b0, a, b, c, 14'd0};
    endfunction

    task automatic start_prog(input logic [AW-1:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = b;
    endtask

    task automatic send(input logic [4:0] op, input logic i,
                        input logic [1:0] md, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] w);
        bit ok = 1'b0;
        ifc.in_opcode = op;
        ifc.in_i      = i;
        ifc.in_mod    = md;
        ifc.in_rd     = rd;
        ifc.in_rs1    = rs1;
        ifc.in_rs2    = rs2;
        ifc.in_imm    = imm;
        ifc.in_last   = last;
        ifc.in_valid  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 64'(ok), 64'd1);
        if (ok) begin
            sb.push_back('{exp_addr, w});
            exp_addr++;
            acc++;
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic finish_prog(input logic [AW:0] n, input logic er,
                               input logic [7:0] ec);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(ok), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd1);
        chk("instr_count", 64'(instr_count), 64'(n));
        chk("err", 64'(err), 64'(er));
        chk("err_count", 64'(err_count), 64'(ec));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_low", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_instr_count"}, 64'(instr_count), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    initial begin
        vt[0]  = '{5'd0,  1'b0, 2'd0, 4'd1,  4'd2,  4'd3,  32'h0000_0000,
                   32'h0048_C000, 1'b0};
        vt[1]  = '{5'd9,  1'b1, 2'd0, 4'd5,  4'd7,  4'd0,  32'hFFFF_FFFF,
                   32'h4D40_FFFF, 1'b0};
        vt[2]  = '{5'd20, 1'b0, 2'd0, 4'd3,  4'd3,  4'd3,  32'h0000_0000,
                   32'hA000_0000, 1'b0};
        vt[3]  = '{5'd18, 1'b0, 2'd0, 4'd3,  4'd4,  4'd0,  32'hFFFF_FFFE,
                   32'h97FF_FFFE, 1'b0};
        vt[4]  = '{5'd21, 1'b0, 2'd0, 4'd1,  4'd2,  4'd3,  32'h0000_0000,
                   32'h6800_0000, 1'b1};
        vt[5]  = '{5'd5,  1'b0, 2'd0, 4'd7,  4'd2,  4'd3,  32'h0000_0000,
                   32'h2808_C000, 1'b0};
        vt[6]  = '{5'd14, 1'b0, 2'd0, 4'd3,  4'd4,  4'd9,  32'h0000_0008,
                   32'h74D0_0008, 1'b0};
        vt[7]  = '{5'd9,  1'b1, 2'd0, 4'd1,  4'd0,  4'd0,  32'h0001_2345,
                   32'h4C40_2345, RC};
        vt[8]  = '{5'd0,  1'b1, 2'd1, 4'd2,  4'd3,  4'd0,  32'h0000_ABCD,
                   32'h048D_ABCD, 1'b0};
        vt[9]  = '{5'd13, 1'b1, 2'd0, 4'd5,  4'd0,  4'd0,  32'h0000_1234,
                   32'h6800_0000, 1'b0};
        vt[10] = '{5'd15, 1'b1, 2'd2, 4'd1,  4'd2,  4'd0,  32'h1234_0000,
                   32'h7C4A_0000, 1'b0};
        vt[11] = '{5'd16, 1'b0, 2'd0, 4'd0,  4'd0,  4'd0,  32'h0800_0000,
                   32'h8000_0000, RC};
        vt[12] = '{5'd8,  1'b0, 2'd0, 4'd2,  4'd9,  4'd4,  32'h0000_0000,
                   32'h4081_0000, 1'b0};
        vt[13] = '{5'd31, 1'b1, 2'd3, 4'd15, 4'd15, 4'd15, 32'hFFFF_FFFF,
                   32'h6800_0000, 1'b1};

        ifc.in_valid  = 1'b0;
        ifc.in_opcode = '0;
        ifc.in_i      = 1'b0;
        ifc.in_mod    = '0;
        ifc.in_rd     = '0;
        ifc.in_rs1    = '0;
        ifc.in_rs2    = '0;
        ifc.in_imm    = '0;
        ifc.in_last   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One-instruction programs from the encode table.
        for (int v = 0; v < 14; v++) begin
            start_prog(10'h010 + AW'(v));
            send(vt[v].op, vt[v].i, vt[v].md, vt[v].rd, vt[v].rs1,
                 vt[v].rs2, vt[v].imm, 1'b1, vt[v].word);
            finish_prog(11'd1, vt[v].err, {7'd0, vt[v].err});
        end

        // Address wrap; a start pulse during LOAD must be ignored.
        start_prog(10'h3FF);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 10'h100;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(5'd9, 1'b1, 2'd0, 4'd5, 4'd7, 4'd0, 32'hFFFF_FFFF,
             1'b0, 32'h4D40_FFFF);
        send(5'd20, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b1,
             32'hA000_0000);
        finish_prog(11'd2, 1'b0, 8'd0);

        // Back-pressure: memory stalls, FIFO fills, handshake stops.
        mem_ready = 1'b0;
        start_prog(10'h040);
        acc = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(5'd0, 1'b0, 2'd0, 4'(k), 4'(k + 1), 4'(k + 2),
                         32'h0, (k == 5), add_word(k));
                end
            end
            begin
                repeat (12) @(negedge clk);
                chk("bp_accepted", 64'(acc), 64'(FD));
                chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
                chk("bp_mem_we", 64'(mem_we), 64'd1);
                chk("bp_addr_hold", 64'(mem_addr), 64'h040);
                chk("bp_data_hold", 64'(mem_wdata), 64'(add_word(0)));
                @(posedge clk);
                #1;
                mem_ready = 1'b1;
            end
        join
        finish_prog(11'd6, 1'b0, 8'd0);

        // Reset in the middle of LOAD discards buffered words.
        mem_ready = 1'b0;
        start_prog(10'h080);
        send(5'd21, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0,
             32'h6800_0000);
        send(5'd0, 1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0,
             32'h0048_C000);
        @(negedge clk);
        chk("pre_rst_err", 64'(err), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_mem_we", 64'(mem_we), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mem_ready = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_write", 64'(mem_we), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader for the SimpleRisc core: the encode direction of the control decoder. It accepts field-level instructions (opcode, I bit, modifier, registers, immediate/offset) over a valid/ready handshake and packs them into 32-bit SimpleRisc words. Encoded words are buffered and written sequentially into instruction memory starting at a programmable base address. It sits between the testbench/boot loader and the instruction memory write port.

## Interface
- AW, 10: instruction-memory word-address width
- FIFO_DEPTH, 4: encoded-word buffer depth (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; honoured only in IDLE; latches base_addr
- base_addr  in  AW  first write address
- in_valid / in_ready  in / out  1  instruction handshake; transfer when both high at a clock edge
- in_opcode  in  5  SimpleRisc opcode
- in_i  in  1  immediate-form bit
- in_mod  in  2  modifier: 00 default, 01 u, 10 h
- in_rd, in_rs1, in_rs2  in  4 each  register fields
- in_imm  in  32  immediate (ALU/ld/st) or branch offset (beq/bgt/b/call)
- in_last  in  1  marks final instruction of the program
- mem_we  out  1  write request; mem_addr / mem_wdata valid while high
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- mem_addr  out  AW;  mem_wdata  out  32
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at program completion
- instr_count  out  AW+1  words written since last start
- err  out  1  sticky error, cleared by start
- err_count  out  8  saturating error count, cleared by start

## Operation
- Fields: [31:27] opcode, [26] I, [25:22] rd, [21:18] rs1, [17:14] rs2 (I=0), [17:16] mod + [15:0] imm (I=1); unused bits 0.
- add/sub/mul/div/mod/and/or/lsl/lsr/asr (0–4, 6, 7, 10–12): full 3-address format.
- cmp (5): rd field forced 0. not (8), mov (9): rs1 field forced 0.
- ld (14), st (15): I forced 1; rd, rs1, mod, imm[15:0].
- beq/bgt/b/call (16–19): [26:0] = in_imm[26:0]. nop (13), ret (20): opcode only.
- Opcode 21–31: illegal; word replaced by NOP 0x6800_0000; err set, err_count += 1.
- FSM: IDLE -(start)-> LOAD -(in_last accepted)-> DRAIN -(FIFO empty, last write accepted)-> DONE -> IDLE.
- in_ready = (LOAD) && FIFO not full; no full-FIFO bypass.
- mem_addr increments on each accepted write; wraps 2^AW−1 → 0 silently.
- instr_count increments per accepted write; err_count saturates at 255.

## Timing
- Reset: state IDLE, FIFO empty, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, instr_count 0, err 0, err_count 0.
- Reset mid-operation aborts immediately; buffered words are discarded, not written.
- Latency: instruction accepted at edge n → mem_we high with its word from cycle n+1 (registered FIFO head).
- mem_we held with stable addr/data until mem_ready; one write per cycle max.
- Simultaneous push and pop permitted when FIFO neither full nor empty.
- start outside IDLE ignored. in_valid outside LOAD ignored (in_ready 0).
- done high exactly one cycle (DONE state); busy drops the following cycle.

## Configuration
- IMM_RANGE_CHECK_EN defined: out-of-range immediates are errors (err set, err_count += 1); word still written truncated. Checks: mod 00 needs in_imm sign-extendable from 16 bits; mod 01 needs in_imm[31:16]=0; mod 10 needs in_imm[15:0]=0; branches need in_imm sign-extendable from 27 bits.
- Undefined: silent truncation; only illegal opcodes raise err.

## Structure
- Shared package simplerisc_pkg: opcode localparams, modifier codes, field bit positions, NOP word, FSM state typedef.
- Sub-module enc_fifo (synchronous FIFO, FIFO_DEPTH×32) holds encoded words; encode logic and FSM stay in the top.

## Test plan
- start, base 0x010; add r1,r2,r3 (op 0, I 0, last) → write 0x0048_C000 @0x010, done pulse, instr_count 1.
- mov r5,#-1 (op 9, I 1, mod 00, imm 0xFFFF_FFFF) then ret → 0x4D40_FFFF @base, 0xA000_0000 @base+1.
- b with offset −2 (op 18) → 0x97FF_FFFE; opcode 21 → 0x6800_0000, err 1, err_count 1.
- mem_ready low 10 cycles, offer 6 instructions → in_ready drops after 4 accepted; all 6 written in order at consecutive addresses.
- base 0x3FF, 2 instructions → addresses 0x3FF then 0x000.
- mov r1,#0x12345 mod 00 → 0x4C40_2345; err 1 with IMM_RANGE_CHECK_EN, 0 without. Reset mid-LOAD → all outputs at reset values next cycle.
